// File: rtl/simon_game_controller_if.sv
// Bus bundle for the Simon game controller: game control, sequence
// generator lookup, player buttons, lamp and status outputs.
interface simon_game_controller_if;
    logic       start;
    logic [1:0] seq_value;
    logic       btn_valid;
    logic [1:0] btn_value;
    logic       seq_hold;
    logic [6:0] seq_index;
    logic       led_on;
    logic [1:0] led_color;
    logic [6:0] round;
    logic [6:0] score;
    logic       game_over;
    logic       win;

    // The game environment: drives controls, generator lookup and buttons.
    modport master (
        output start, seq_value, btn_valid, btn_value,
        input  seq_hold, seq_index, led_on, led_color, round, score, game_over, win
    );

    // The controller itself.
    modport slave (
        input  start, seq_value, btn_valid, btn_value,
        output seq_hold, seq_index, led_on, led_color, round, score, game_over, win
    );
endinterface

// File: rtl/simon_game_controller.sv
// Simon game controller: plays back a growing colour sequence, checks the
// player's presses against it, and tracks round, score, win and loss.
module simon_game_controller #(
    parameter int SEQ_LEN        = 100,
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input logic                    clk,
    input logic                    rst,
    simon_game_controller_if.slave bus
);

    // One shared timer, wide enough for the longest interval it has to count.
    localparam int MAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_P = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int TW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    LAST_ROUND   = 7'(SEQ_LEN);

    typedef enum logic [2:0] {
        IDLE, ROUND_GAP, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE
    } state_t;

    state_t        r_state, w_stateNext;
    logic [TW-1:0] r_timer, w_timerNext;
    logic [6:0]    r_seqIndex, w_seqIndexNext;
    logic [6:0]    r_round, w_roundNext;
    logic [6:0]    r_score, w_scoreNext;
    logic          r_seqHold, r_ledOn, r_gameOver, r_win;
    logic          w_seqHoldNext, w_ledOnNext, w_gameOverNext, w_winNext;
    logic          w_gapDone, w_showDone, w_timeout, w_lastIdx, w_match;

    assign w_gapDone  = (r_timer == GAP_LAST);
    assign w_showDone = (r_timer == SHOW_LAST);
    assign w_timeout  = (r_timer == TIMEOUT_LAST);
    assign w_lastIdx  = (r_seqIndex == r_round - 7'd1);
    assign w_match    = (bus.btn_value == bus.seq_value);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    // Next-state logic: timed playback, then player input with timeout.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:      if (bus.start) w_stateNext = ROUND_GAP;
            ROUND_GAP: if (w_gapDone) w_stateNext = SHOW_ON;
            SHOW_ON:   if (w_showDone) w_stateNext = SHOW_OFF;
            SHOW_OFF:  if (w_gapDone) w_stateNext = w_lastIdx ? INPUT : SHOW_ON;
            INPUT: begin
                if (bus.btn_valid) begin
                    if (!w_match)
                        w_stateNext = LOSE;
                    else if (w_lastIdx)
                        w_stateNext = (r_round == LAST_ROUND) ? WIN : ROUND_GAP;
                end else if (w_timeout) begin
                    w_stateNext = LOSE;
                end
            end
            WIN, LOSE: if (bus.start) w_stateNext = IDLE;
            default:   w_stateNext = IDLE;
        endcase
    end

    // Output logic: next values of the timer, counters and status flags.
    always_comb begin
        w_timerNext    = (w_stateNext == r_state) ? r_timer + 1'b1 : '0;
        w_seqIndexNext = r_seqIndex;
        w_roundNext    = r_round;
        w_scoreNext    = r_score;
        case (r_state)
            IDLE: begin
                w_timerNext = '0;
                if (bus.start) begin
                    w_roundNext    = 7'd1;
                    w_scoreNext    = 7'd0;
                    w_seqIndexNext = 7'd0;
                end
            end
            SHOW_OFF: begin
                if (w_gapDone)
                    w_seqIndexNext = w_lastIdx ? 7'd0 : r_seqIndex + 7'd1;
            end
            INPUT: begin
                if (bus.btn_valid) begin
                    w_timerNext = '0;
                    if (w_match) begin
                        if (!w_lastIdx) begin
                            w_seqIndexNext = r_seqIndex + 7'd1;
                        end else begin
                            w_scoreNext = r_score + 7'd1;
                            if (r_round != LAST_ROUND) begin
                                w_roundNext    = r_round + 7'd1;
                                w_seqIndexNext = 7'd0;
                            end
                        end
                    end
                end
            end
            WIN, LOSE: begin
                w_timerNext = '0;
                if (bus.start) begin
                    w_roundNext    = 7'd0;
                    w_scoreNext    = 7'd0;
                    w_seqIndexNext = 7'd0;
                end
            end
            default: ;
        endcase
        w_seqHoldNext  = (w_stateNext != IDLE);
        w_ledOnNext    = (w_stateNext == SHOW_ON);
        w_gameOverNext = (w_stateNext == LOSE);
        w_winNext      = (w_stateNext == WIN);
    end

    // Datapath and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer    <= '0;
            r_seqIndex <= '0;
            r_round    <= '0;
            r_score    <= '0;
            r_seqHold  <= 1'b0;
            r_ledOn    <= 1'b0;
            r_gameOver <= 1'b0;
            r_win      <= 1'b0;
        end else begin
            r_timer    <= w_timerNext;
            r_seqIndex <= w_seqIndexNext;
            r_round    <= w_roundNext;
            r_score    <= w_scoreNext;
            r_seqHold  <= w_seqHoldNext;
            r_ledOn    <= w_ledOnNext;
            r_gameOver <= w_gameOverNext;
            r_win      <= w_winNext;
        end
    end

    // The lamp colour gates the generator lookup with the registered lamp
    // enable, so it always shows the element at the current seq_index even
    // in the cycle the index advances.
    assign bus.led_color = r_ledOn ? bus.seq_value : 2'd0;
    assign bus.seq_hold  = r_seqHold;
    assign bus.seq_index = r_seqIndex;
    assign bus.led_on    = r_ledOn;
    assign bus.round     = r_round;
    assign bus.score     = r_score;
    assign bus.game_over = r_gameOver;
    assign bus.win       = r_win;

endmodule
